// File: rtl/uart_rx.sv
// UART receiver: 2-flop line sync, start-edge detect, mid-bit sampling, single-cycle result strobes.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLOCK_RATE     = 50000000,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned CYCLES_PER_BIT = (CLOCK_RATE / BAUD_RATE) - 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_w,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_parity_err
);

  localparam int unsigned TW = $clog2(CYCLES_PER_BIT + 1);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] FULL_TGT = TW'(CYCLES_PER_BIT);
  localparam logic [TW-1:0] HALF_TGT = TW'(((CYCLES_PER_BIT + 1) / 2) - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

  logic                 meta_q, rx_s_q, rx_d_q;
  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 tick_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  // Line synchroniser; presets to idle-high so reset never looks like a start edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      meta_q <= i_rx_w;
      rx_s_q <= meta_q;
      rx_d_q <= rx_s_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Half-bit target in ST_START lands subsequent full-bit ticks on bit centres
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    tick_c  = (timer_q == ((state_q == ST_START) ? HALF_TGT : FULL_TGT));
    timer_d = ((state_q == ST_IDLE) || tick_c) ? '0 : timer_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (rx_d_q && !rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (tick_c) begin
          idx_d   = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_c) begin
          par_bad_d = (^shift_q) ^ rx_s_q;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick_c) begin
          state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad_q;
          if (rx_s_q && !par_bad_q) begin
`else
          if (rx_s_q) begin
`endif
            data_d  = shift_q;
            valid_d = 1'b1;
          end
          ferr_d = !rx_s_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at P=16 clocks per bit, DATA_BITS=8.
module tb_uart_rx;

  localparam int P = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // drive cycle -> strobe cycle: 2 sync flops + P/2 + P*(8+1+PAR) + 1
  localparam int LAT       = 2 + 8 + P * (9 + PAR) + 1;
  localparam int FRAME     = P * (10 + PAR);
  localparam int BUSY_FULL = 8 + P * (9 + PAR);

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid, busy, ferr, perr;

  int cyc = 0;
  int vectors = 0;
  int errors = 0;

  int         vcnt, fecnt, pecnt, busy_cnt;
  int         vcyc[8];
  logic [7:0] vdat[8];
  int         fecyc, pecyc;

  uart_rx #(
    .CLOCK_RATE(1600000),
    .BAUD_RATE (100000),
    .DATA_BITS (8)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_rx_w      (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_busy      (busy),
    .o_frame_err (ferr),
    .o_parity_err(perr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output log sampled on the falling edge
  always @(negedge clk) begin
    if (valid) begin
      if (vcnt < 8) begin
        vcyc[vcnt] = cyc;
        vdat[vcnt] = data;
      end
      vcnt = vcnt + 1;
    end
    if (ferr) begin
      fecnt = fecnt + 1;
      fecyc = cyc;
    end
    if (perr) begin
      pecnt = pecnt + 1;
      pecyc = cyc;
    end
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic clear_log();
    vcnt = 0; fecnt = 0; pecnt = 0; busy_cnt = 0; fecyc = -1; pecyc = -1;
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (P) @(posedge clk);
    #1;
  endtask

  // Caller must be aligned (posedge + #1); returns aligned, with the line left at the stop value
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip, output int c);
    c = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR != 0) drive_bit((^d) ^ par_flip);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
    repeat (200) @(posedge clk);
    #1;
    vectors++; if (vcnt !== 0)     begin errors++; $display("FAIL reset_valid: got %0d pulses, want 0", vcnt); end
    vectors++; if (busy_cnt !== 0) begin errors++; $display("FAIL reset_busy: got %0d busy cycles, want 0", busy_cnt); end
    vectors++; if (fecnt + pecnt !== 0) begin errors++; $display("FAIL reset_err: got %0d error pulses, want 0", fecnt + pecnt); end
    vectors++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, want 00", data); end
  endtask

  task automatic test_single();
    int c;
    clear_log();
    align();
    send_frame(8'hA5, 1'b1, 1'b0, c);
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (vcnt !== 1) begin errors++; $display("FAIL single_count: got %0d pulses, want 1", vcnt); end
    vectors++; if (vcyc[0] !== c + LAT) begin errors++; $display("FAIL single_latency: got cycle %0d, want %0d", vcyc[0], c + LAT); end
    vectors++; if (vdat[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h, want a5", vdat[0]); end
    vectors++; if (busy_cnt !== BUSY_FULL) begin errors++; $display("FAIL single_busy: got %0d busy cycles, want %0d", busy_cnt, BUSY_FULL); end
    vectors++; if (fecnt + pecnt !== 0) begin errors++; $display("FAIL single_err: got %0d error pulses, want 0", fecnt + pecnt); end
  endtask

  task automatic test_back_to_back();
    int c0, c1;
    clear_log();
    align();
    send_frame(8'h00, 1'b1, 1'b0, c0);
    send_frame(8'hFF, 1'b1, 1'b0, c1);
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (vcnt !== 2) begin errors++; $display("FAIL b2b_count: got %0d pulses, want 2", vcnt); end
    vectors++; if (vcyc[0] !== c0 + LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d, want %0d", vcyc[0], c0 + LAT); end
    vectors++; if (vcyc[1] - vcyc[0] !== FRAME) begin errors++; $display("FAIL b2b_spacing: got %0d, want %0d", vcyc[1] - vcyc[0], FRAME); end
    vectors++; if (vdat[0] !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h, want 00", vdat[0]); end
    vectors++; if (vdat[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h, want ff", vdat[1]); end
  endtask

  task automatic test_glitch();
    clear_log();
    align();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    vectors++; if (busy_cnt !== 8) begin errors++; $display("FAIL glitch_busy: got %0d busy cycles, want 8", busy_cnt); end
    vectors++; if (vcnt + fecnt + pecnt !== 0) begin errors++; $display("FAIL glitch_strobe: got %0d strobes, want 0", vcnt + fecnt + pecnt); end
    vectors++; if (data !== 8'hFF) begin errors++; $display("FAIL glitch_data: got %h, want ff", data); end
  endtask

  task automatic test_frame_err();
    int c;
    clear_log();
    align();
    send_frame(8'h3C, 1'b0, 1'b0, c);
    repeat (40) @(posedge clk);
    #1;
    vectors++; if (fecnt !== 1) begin errors++; $display("FAIL ferr_count: got %0d pulses, want 1", fecnt); end
    vectors++; if (fecyc !== c + LAT) begin errors++; $display("FAIL ferr_latency: got %0d, want %0d", fecyc, c + LAT); end
    vectors++; if (vcnt !== 0) begin errors++; $display("FAIL ferr_valid: got %0d pulses, want 0", vcnt); end
    vectors++; if (data !== 8'hFF) begin errors++; $display("FAIL ferr_data_kept: got %h, want ff", data); end
    vectors++; if (busy_cnt !== BUSY_FULL) begin errors++; $display("FAIL ferr_no_retrigger: got %0d busy cycles, want %0d", busy_cnt, BUSY_FULL); end
    rx = 1'b1;
    repeat (20) @(posedge clk);
    clear_log();
    align();
    send_frame(8'h5A, 1'b1, 1'b0, c);
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (vcnt !== 1 || data !== 8'h5A) begin errors++; $display("FAIL ferr_recover: got %0d pulses data %h, want 1 pulse data 5a", vcnt, data); end
  endtask

  task automatic test_parity();
    int c;
    clear_log();
    align();
    send_frame(8'h07, 1'b1, 1'b0, c);
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (vcnt !== 1 || vdat[0] !== 8'h07) begin errors++; $display("FAIL parity_good: got %0d pulses data %h, want 1 pulse data 07", vcnt, vdat[0]); end
    vectors++; if (pecnt !== 0) begin errors++; $display("FAIL parity_good_perr: got %0d, want 0", pecnt); end
    clear_log();
    align();
    send_frame(8'h07, 1'b1, 1'b1, c);
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (pecnt !== 1) begin errors++; $display("FAIL parity_bad_count: got %0d pulses, want 1", pecnt); end
    vectors++; if (pecyc !== c + LAT) begin errors++; $display("FAIL parity_bad_latency: got %0d, want %0d", pecyc, c + LAT); end
    vectors++; if (vcnt !== 0 || fecnt !== 0) begin errors++; $display("FAIL parity_bad_other: got valid %0d ferr %0d, want 0 0", vcnt, fecnt); end
    vectors++; if (data !== 8'h07) begin errors++; $display("FAIL parity_bad_data: got %h, want 07", data); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    align();
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (54) @(posedge clk);
    #1;
    vectors++; if (busy_cnt !== 67) begin errors++; $display("FAIL rstmid_busy_before: got %0d busy cycles, want 67", busy_cnt); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b, want 0", busy); end
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    vectors++; if (vcnt + fecnt + pecnt !== 0) begin errors++; $display("FAIL rstmid_strobe: got %0d strobes, want 0", vcnt + fecnt + pecnt); end
    vectors++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h, want 00", data); end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    clear_log();
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    if (PAR != 0) test_parity();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
